// File: rtl/usb_hub_pkg.sv
// -----------------------------------------------------------------------------
// usb_hub_pkg
// Shared definitions for the hub's transaction-retry logic:
//   - nak_state_e      : state encoding of the NAK/timeout retry controller
//   - DEF_*            : default retry count, backoff length and response timeout
//   - RETRY_CNT_W      : width of the retry counter exposed on the controller
//   - timer_width()    : width of a counter able to hold 0 .. max(a,b)-1
// -----------------------------------------------------------------------------
package usb_hub_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_TX   = 3'd2,
        ST_WAIT_RESP = 3'd3,
        ST_BACKOFF   = 3'd4,
        ST_FAIL      = 3'd5
    } nak_state_e;

    localparam int unsigned DEF_MAX_RETRY      = 3;
    localparam int unsigned DEF_BACKOFF_CYCLES = 16;
    localparam int unsigned DEF_RESP_TIMEOUT   = 64;

    localparam int unsigned RETRY_CNT_W = 4;

    // The shared timer only ever has to reach (terminal - 1) for the larger of
    // the two intervals it measures, so it needs clog2 of that interval.
    function automatic int unsigned timer_width(input int unsigned a,
                                                input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/retry_timer.sv
// -----------------------------------------------------------------------------
// retry_timer
// Clearable up-counter with a terminal-count compare. The retry controller
// reuses one instance to time both the response window and the backoff gap,
// swapping the terminal value according to its state.
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset, forces the count to 0
//   clr      : synchronous clear, takes priority over en
//   en       : count enable
//   terminal : value at which tc asserts
//   tc       : high while count == terminal
// -----------------------------------------------------------------------------
module retry_timer #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] terminal,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values of its inputs, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            // Hold at the terminal value rather than wrapping, so tc stays
            // asserted until the owner clears or moves on.
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == terminal);

endmodule

// File: rtl/nak_retry_controller.sv
// -----------------------------------------------------------------------------
// nak_retry_controller
// Drives one host transaction through send / wait-for-handshake, retrying
// after a fixed backoff whenever the device NAKs or stays silent, and giving
// up once MAX_RETRY retries have been spent.
//
// Parameters
//   MAX_RETRY      : retries allowed after the first attempt (1..15)
//   BACKOFF_CYCLES : idle cycles between a failed attempt and the resend (>=1)
//   RESP_TIMEOUT   : cycles to wait for a handshake after tx_done (>=2)
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   txn_req      : host requests a transaction (sampled only while txn_ready)
//   tx_done      : transmitter end-of-packet pulse
//   ack_detected : ACK PID received pulse
//   nak_detected : NAK detected pulse
//   txn_ready    : high only in IDLE
//   tx_start     : one-cycle pulse commanding a (re)send
//   txn_ok       : one-cycle pulse, transaction acknowledged
//   txn_fail     : one-cycle pulse, retries exhausted
//   retry_cnt    : retries issued for the current transaction
// -----------------------------------------------------------------------------
module nak_retry_controller
    import usb_hub_pkg::*;
#(
    parameter int unsigned MAX_RETRY      = DEF_MAX_RETRY,
    parameter int unsigned BACKOFF_CYCLES = DEF_BACKOFF_CYCLES,
    parameter int unsigned RESP_TIMEOUT   = DEF_RESP_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   txn_req,
    input  logic                   tx_done,
    input  logic                   ack_detected,
    input  logic                   nak_detected,
    output logic                   txn_ready,
    output logic                   tx_start,
    output logic                   txn_ok,
    output logic                   txn_fail,
    output logic [RETRY_CNT_W-1:0] retry_cnt
);

    localparam int unsigned TIMER_W = timer_width(BACKOFF_CYCLES, RESP_TIMEOUT);

    // Terminal counts are one less than the interval because the timer is
    // cleared to 0 on entry to the state and that first cycle counts.
    localparam logic [TIMER_W-1:0] BACKOFF_TC = TIMER_W'(BACKOFF_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RESP_TC    = TIMER_W'(RESP_TIMEOUT - 1);
    localparam logic [RETRY_CNT_W-1:0] RETRY_LIMIT = RETRY_CNT_W'(MAX_RETRY);

    nak_state_e             state;
    nak_state_e             state_next;
    logic [RETRY_CNT_W-1:0] retry_cnt_next;
    logic                   txn_ok_next;

    logic                   timer_clr;
    logic                   timer_en;
    logic                   timer_tc;
    logic [TIMER_W-1:0]     timer_terminal;

    // -------------------------------------------------------------------------
    // Shared timer: backoff length in BACKOFF, response window otherwise.
    // Selected from state alone so the compare never depends on next-state.
    // -------------------------------------------------------------------------
    assign timer_terminal = (state == ST_BACKOFF) ? BACKOFF_TC : RESP_TC;

    retry_timer #(
        .WIDTH (TIMER_W)
    ) u_retry_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (timer_clr),
        .en       (timer_en),
        .terminal (timer_terminal),
        .tc       (timer_tc)
    );

    // -------------------------------------------------------------------------
    // State, retry counter and the registered txn_ok pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            retry_cnt <= '0;
            txn_ok    <= 1'b0;
        end else begin
            state     <= state_next;
            retry_cnt <= retry_cnt_next;
            txn_ok    <= txn_ok_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_next     = state;
        retry_cnt_next = retry_cnt;
        txn_ok_next    = 1'b0;
        timer_clr      = 1'b0;
        timer_en       = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (txn_req) begin
                    retry_cnt_next = '0;
                    state_next     = ST_SEND;
                end
            end

            ST_SEND: begin
                state_next = ST_WAIT_TX;
            end

            ST_WAIT_TX: begin
                if (tx_done) begin
                    timer_clr  = 1'b1;
                    state_next = ST_WAIT_RESP;
                end
            end

            ST_WAIT_RESP: begin
                timer_en = 1'b1;
                // ACK wins over a simultaneous NAK or timer expiry.
                if (ack_detected) begin
                    txn_ok_next = 1'b1;
                    state_next  = ST_IDLE;
                end else if (nak_detected || timer_tc) begin
                    if (retry_cnt < RETRY_LIMIT) begin
                        retry_cnt_next = retry_cnt + RETRY_CNT_W'(1);
                        timer_clr      = 1'b1;
                        state_next     = ST_BACKOFF;
                    end else begin
                        state_next = ST_FAIL;
                    end
                end
            end

            ST_BACKOFF: begin
                timer_en = 1'b1;
                if (timer_tc) begin
                    timer_clr  = 1'b1;
                    state_next = ST_SEND;
                end
            end

            ST_FAIL: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Moore outputs; reset forces IDLE, so they take their idle values at once.
    // -------------------------------------------------------------------------
    assign txn_ready = (state == ST_IDLE);
    assign tx_start  = (state == ST_SEND);
    assign txn_fail  = (state == ST_FAIL);

endmodule

// File: tb/tb_nak_retry_controller.sv
// -----------------------------------------------------------------------------
// tb_nak_retry_controller
// Directed bench for nak_retry_controller with default parameters
// (MAX_RETRY=3, BACKOFF_CYCLES=16, RESP_TIMEOUT=64). Inputs are driven 1 ns
// after each rising edge and outputs are read in the same window; pulse
// counters sample on the falling edge.
// -----------------------------------------------------------------------------
module tb_nak_retry_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       txn_req;
    logic       tx_done;
    logic       ack_detected;
    logic       nak_detected;
    logic       txn_ready;
    logic       tx_start;
    logic       txn_ok;
    logic       txn_fail;
    logic [3:0] retry_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_start  = 0;
    int n_ok     = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nak_retry_controller dut (
        .clk          (clk),
        .rst          (rst),
        .txn_req      (txn_req),
        .tx_done      (tx_done),
        .ack_detected (ack_detected),
        .nak_detected (nak_detected),
        .txn_ready    (txn_ready),
        .tx_start     (tx_start),
        .txn_ok       (txn_ok),
        .txn_fail     (txn_fail),
        .retry_cnt    (retry_cnt)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (tx_start) n_start++;
        if (txn_ok)   n_ok++;
        if (txn_fail) n_fail++;
    end

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until tx_start is seen or the budget runs out.
    task automatic wait_start(input string tag, input int budget);
        for (int i = 0; i < budget && !tx_start; i++) step();
        check(tag, int'(tx_start), 1);
    endtask

    int s0, f0, o0, d, nak_cyc;

    initial begin
        rst          = 1'b1;
        txn_req      = 1'b0;
        tx_done      = 1'b0;
        ack_detected = 1'b0;
        nak_detected = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_txn_ready", int'(txn_ready), 1);
        check("rst_tx_start",  int'(tx_start),  0);
        check("rst_txn_ok",    int'(txn_ok),    0);
        check("rst_txn_fail",  int'(txn_fail),  0);
        check("rst_retry_cnt", int'(retry_cnt), 0);
        rst = 1'b0;
        step();

        // ---------------- T1: tx_done, ACK 3 cycles later ----------------
        s0 = n_start;
        txn_req = 1'b1;
        step();
        txn_req = 1'b0;
        check("t1_start_latency", int'(tx_start),  1);
        check("t1_not_ready",     int'(txn_ready), 0);
        step();
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        step();
        step();
        ack_detected = 1'b1;
        step();
        ack_detected = 1'b0;
        check("t1_txn_ok",    int'(txn_ok),    1);
        check("t1_ready",     int'(txn_ready), 1);
        step();
        check("t1_ok_pulse",  int'(txn_ok),    0);
        check("t1_start_cnt", n_start - s0,    1);
        check("t1_retry_cnt", int'(retry_cnt), 0);

        // ---------------- T2: NAK on every attempt ----------------
        s0 = n_start;
        f0 = n_fail;
        txn_req = 1'b1;
        step();
        txn_req = 1'b0;
        for (int a = 0; a < 4; a++) begin
            wait_start("t2_start", 40);
            if (a > 0) check("t2_retry_latency", cyc - nak_cyc, 17);
            step();
            tx_done = 1'b1;
            step();
            tx_done = 1'b0;
            nak_detected = 1'b1;
            nak_cyc = cyc;
            step();
            nak_detected = 1'b0;
            if (a < 3) check("t2_retry_cnt", int'(retry_cnt), a + 1);
        end
        check("t2_txn_fail",   int'(txn_fail),  1);
        check("t2_retry_max",  int'(retry_cnt), 3);
        step();
        check("t2_fail_pulse", int'(txn_fail),  0);
        check("t2_ready",      int'(txn_ready), 1);
        check("t2_start_cnt",  n_start - s0,    4);
        check("t2_fail_cnt",   n_fail - f0,     1);
        repeat (5) step();
        check("t2_retry_hold", int'(retry_cnt), 3);

        // ---------------- T3: response timeout ----------------
        s0 = n_start;
        txn_req = 1'b1;
        step();
        txn_req = 1'b0;
        check("t3_retry_clr", int'(retry_cnt), 0);
        step();
        tx_done = 1'b1;
        d = cyc;
        step();
        tx_done = 1'b0;
        while (cyc < d + 64) step();
        check("t3_pre_timeout", int'(retry_cnt), 0);
        step();
        check("t3_timeout_retry", int'(retry_cnt), 1);
        wait_start("t3_restart", 40);
        check("t3_restart_latency", cyc - d, 81);
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        ack_detected = 1'b1;
        step();
        ack_detected = 1'b0;
        check("t3_txn_ok",     int'(txn_ok),    1);
        check("t3_retry_hold", int'(retry_cnt), 1);
        check("t3_start_cnt",  n_start - s0,    2);

        // ---------------- T6a: NAK while IDLE ----------------
        s0 = n_start;
        step();
        nak_detected = 1'b1;
        step();
        nak_detected = 1'b0;
        check("t6_idle_ready", int'(txn_ready), 1);
        check("t6_idle_retry", int'(retry_cnt), 1);
        repeat (3) step();
        check("t6_idle_no_start", n_start - s0, 0);

        // ---------------- T6b: NAK while WAIT_TX ----------------
        s0 = n_start;
        txn_req = 1'b1;
        step();
        txn_req = 1'b0;
        step();
        nak_detected = 1'b1;
        step();
        nak_detected = 1'b0;
        check("t6_wtx_ready", int'(txn_ready), 0);
        check("t6_wtx_retry", int'(retry_cnt), 0);
        repeat (20) step();
        check("t6_wtx_no_resend", n_start - s0, 1);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        ack_detected = 1'b1;
        step();
        ack_detected = 1'b0;
        check("t6_wtx_ok",    int'(txn_ok),    1);
        check("t6_wtx_retry_end", int'(retry_cnt), 0);

        // ---------------- T4: ACK and NAK together ----------------
        s0 = n_start;
        step();
        txn_req = 1'b1;
        step();
        txn_req = 1'b0;
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        ack_detected = 1'b1;
        nak_detected = 1'b1;
        step();
        ack_detected = 1'b0;
        nak_detected = 1'b0;
        check("t4_txn_ok", int'(txn_ok),    1);
        check("t4_retry",  int'(retry_cnt), 0);
        check("t4_ready",  int'(txn_ready), 1);
        repeat (30) step();
        check("t4_no_retry", n_start - s0, 1);

        // ---------------- T4b: ACK on the timeout cycle ----------------
        s0 = n_start;
        txn_req = 1'b1;
        step();
        txn_req = 1'b0;
        step();
        tx_done = 1'b1;
        d = cyc;
        step();
        tx_done = 1'b0;
        while (cyc < d + 64) step();
        ack_detected = 1'b1;
        step();
        ack_detected = 1'b0;
        check("t4b_txn_ok", int'(txn_ok),    1);
        check("t4b_retry",  int'(retry_cnt), 0);
        repeat (30) step();
        check("t4b_no_retry", n_start - s0, 1);

        // ---------------- T5: reset during BACKOFF ----------------
        s0 = n_start;
        f0 = n_fail;
        o0 = n_ok;
        txn_req = 1'b1;
        step();
        txn_req = 1'b0;
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        nak_detected = 1'b1;
        step();
        nak_detected = 1'b0;
        check("t5_in_backoff", int'(retry_cnt), 1);
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        check("t5_rst_ready",    int'(txn_ready), 1);
        check("t5_rst_retry",    int'(retry_cnt), 0);
        check("t5_rst_tx_start", int'(tx_start),  0);
        step();
        step();
        rst = 1'b0;
        repeat (30) step();
        check("t5_no_resend", n_start - s0, 1);
        check("t5_no_fail",   n_fail - f0,  0);
        check("t5_no_ok",     n_ok - o0,    0);
        check("t5_ready",     int'(txn_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
